// File: rtl/led_pkg.sv
// Shared encodings and register field offsets for the LED driver family.
package led_pkg;

  localparam logic [1:0] LED_MODE_STATIC  = 2'b00;
  localparam logic [1:0] LED_MODE_BLINK   = 2'b01;
  localparam logic [1:0] LED_MODE_PWM     = 2'b10;
  localparam logic [1:0] LED_MODE_BREATHE = 2'b11;

  localparam int LED_DUTY_LSB = 0;
  localparam int LED_BLINK_W  = 16;

endpackage

// File: rtl/led_timebase.sv
// Shared prescaler and PWM timebase: tick every PRESCALE clks, PWM counter
// advancing on tick, and a pulse on the tick where the counter wraps.
module led_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 100
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                tick,
  output logic                pwm_period_end,
  output logic [PWM_BITS-1:0] pwm_cnt
);

  localparam int                PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

  logic [PW-1:0]       pre_cnt, pre_nxt;
  logic [PWM_BITS-1:0] cnt_nxt;

  always_comb begin
    pre_nxt = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    cnt_nxt = tick ? pwm_cnt + 1'b1 : pwm_cnt;
  end

  // tick/pwm_period_end are decoded from next-state so they are flops that
  // line up exactly with the cycle where pre_cnt sits at its last value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt        <= '0;
      pwm_cnt        <= '0;
      tick           <= 1'b0;
      pwm_period_end <= 1'b0;
    end else begin
      pre_cnt        <= pre_nxt;
      pwm_cnt        <= cnt_nxt;
      tick           <= (pre_nxt == PRE_LAST);
      pwm_period_end <= (pre_nxt == PRE_LAST) && (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: per-channel static / blink / PWM (and breathe when
// LED_PWM_CTRL_BREATHE_EN is defined; otherwise mode 11 acts as static).
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter int LED_NUM  = 4,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 100
) (
  input  logic               clk,
  input  logic               resetn,
  output logic [LED_NUM-1:0] led,
  output logic               tick,
  output logic               pwm_period_end,
  input  logic [31:0]        led_state,
  input  logic [31:0]        led_mode,
  input  logic [31:0]        led_duty,
  input  logic [31:0]        led_blink
);

  logic [PWM_BITS-1:0]    pwm_cnt, duty_shadow;
  logic [LED_BLINK_W-1:0] blink_hp, blink_cnt;
  logic                   blink_phase, pwm_on;
  logic [LED_NUM-1:0]     led_nxt;
  logic                   unused_bits;

  led_timebase #(
    .PWM_BITS(PWM_BITS),
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk(clk),
    .resetn(resetn),
    .tick(tick),
    .pwm_period_end(pwm_period_end),
    .pwm_cnt(pwm_cnt)
  );

  assign blink_hp    = led_blink[LED_BLINK_W-1:0];
  assign pwm_on      = pwm_cnt < duty_shadow;
  assign unused_bits = ^{led_state, led_mode, led_duty, led_blink};

  // Duty only changes at the period boundary so a mid-period write never glitches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             duty_shadow <= '0;
    else if (pwm_period_end) duty_shadow <= led_duty[LED_DUTY_LSB +: PWM_BITS];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_hp == '0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == blink_hp - 1'b1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 1'b1;
      end
    end
  end

`ifdef LED_PWM_CTRL_BREATHE_EN
  localparam logic [PWM_BITS-1:0] BR_MAX = '1;
  logic [PWM_BITS-1:0] br_level;
  logic                br_down, br_on;

  // Triangle ramp 0..max..0, one step per PWM period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_level <= '0;
      br_down  <= 1'b0;
    end else if (pwm_period_end) begin
      if (!br_down) begin
        br_level <= br_level + 1'b1;
        if (br_level == BR_MAX - 1'b1) br_down <= 1'b1;
      end else begin
        br_level <= br_level - 1'b1;
        if (br_level == PWM_BITS'(1)) br_down <= 1'b0;
      end
    end
  end

  assign br_on = pwm_cnt < br_level;
`endif

  for (genvar i = 0; i < LED_NUM; i++) begin : g_ch
    logic       s, nxt;
    logic [1:0] mode;
    assign s    = led_state[i];
    assign mode = led_mode[2*i +: 2];
    always_comb begin
      nxt = s;
      case (mode)
        LED_MODE_STATIC:  nxt = s;
        LED_MODE_BLINK:   nxt = s & blink_phase;
        LED_MODE_PWM:     nxt = s & pwm_on;
`ifdef LED_PWM_CTRL_BREATHE_EN
        LED_MODE_BREATHE: nxt = s & br_on;
`else
        LED_MODE_BREATHE: nxt = s;
`endif
      endcase
    end
    assign led_nxt[i] = nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) led <= '0;
    else         led <= led_nxt;
  end

endmodule
